stream_merger: RTL and testbench

Receive-side counterpart to the `router` crossbar. It accepts the two 8-bit streams that leave the router (`x`-side and `y`-side) over valid/ready handshakes and buffers each in a small per-input FIFO. It merges them onto one registered output stream, tagging every word with its source port. Round-robin arbitration guarantees neither input starves, and the block sustains one word per clock when the consumer is always ready.

---
 rtl/stream_merger.sv | 127 ++++++++++++
 tb/tb_stream_merger.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_merger.sv
// stream_merger: merges two valid/ready byte streams (A, B) into one
// registered output stream tagged with its source, via per-input FIFOs.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   a_valid/a_data/a_ready  input stream A (a_ready = FIFO A not full)
//   b_valid/b_data/b_ready  input stream B (b_ready = FIFO B not full)
//   out_valid/out_data      merged output word (registered)
//   out_src/out_ready       source tag (0 = A, 1 = B), consumer ready
//   a_level, b_level        FIFO occupancy, 0..DEPTH
module stream_merger #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     a_valid,
   input  logic [WIDTH-1:0]         a_data,
   output logic                     a_ready,
   input  logic                     b_valid,
   input  logic [WIDTH-1:0]         b_data,
   output logic                     b_ready,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_src,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   a_level,
   output logic [$clog2(DEPTH):0]   b_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] a_mem [DEPTH];
   logic [WIDTH-1:0] b_mem [DEPTH];
   logic [AW-1:0]    a_wp, a_rp;
   logic [AW-1:0]    b_wp, b_rp;
   logic             a_push, a_pop;
   logic             b_push, b_pop;
   logic             a_ne, b_ne;
   logic             slot_free;
   logic             last_grant;

   // ready depends on the registered level only: no pass-through
   assign a_ready   = (a_level != LW'(DEPTH));
   assign b_ready   = (b_level != LW'(DEPTH));
   assign a_push    = a_valid && a_ready;
   assign b_push    = b_valid && b_ready;
   assign a_ne      = (a_level != '0);
   assign b_ne      = (b_level != '0);
   assign slot_free = !out_valid || out_ready;

   // round-robin: on a tie, serve the port not granted last time
   always_comb begin
      a_pop = 1'b0;
      b_pop = 1'b0;
      if (slot_free) begin
         if (a_ne && b_ne) begin
            a_pop = last_grant;
            b_pop = !last_grant;
         end else if (a_ne) begin
            a_pop = 1'b1;
         end else if (b_ne) begin
            b_pop = 1'b1;
         end
      end
   end

   // storage arrays carry no reset; pointers and levels qualify them
   always_ff @(posedge clk) begin
      if (a_push) a_mem[a_wp] <= a_data;
      if (b_push) b_mem[b_wp] <= b_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_wp    <= '0;
         a_rp    <= '0;
         a_level <= '0;
      end else begin
         if (a_push) a_wp <= a_wp + AW'(1);
         if (a_pop)  a_rp <= a_rp + AW'(1);
         case ({a_push, a_pop})
            2'b10:   a_level <= a_level + LW'(1);
            2'b01:   a_level <= a_level - LW'(1);
            default: a_level <= a_level;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_wp    <= '0;
         b_rp    <= '0;
         b_level <= '0;
      end else begin
         if (b_push) b_wp <= b_wp + AW'(1);
         if (b_pop)  b_rp <= b_rp + AW'(1);
         case ({b_push, b_pop})
            2'b10:   b_level <= b_level + LW'(1);
            2'b01:   b_level <= b_level - LW'(1);
            default: b_level <= b_level;
         endcase
      end
   end

   // output slot; last_grant resets to B so the first tie goes to A
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_src    <= 1'b0;
         last_grant <= 1'b1;
      end else if (slot_free) begin
         out_valid <= a_pop || b_pop;
         if (a_pop) begin
            out_data   <= a_mem[a_rp];
            out_src    <= 1'b0;
            last_grant <= 1'b0;
         end else if (b_pop) begin
            out_data   <= b_mem[b_rp];
            out_src    <= 1'b1;
            last_grant <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_stream_merger.sv
// tb_stream_merger: directed stimulus for stream_merger, checked every
// cycle against a queue-based model plus literal expectations.
module tb_stream_merger;

   localparam int WIDTH = 8;
   localparam int DEPTH = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             a_valid = 1'b0;
   logic [WIDTH-1:0] a_data = '0;
   logic             a_ready;
   logic             b_valid = 1'b0;
   logic [WIDTH-1:0] b_data = '0;
   logic             b_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_src;
   logic             out_ready = 1'b1;
   logic [1:0]       a_level;
   logic [1:0]       b_level;

   stream_merger #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
      .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
      .out_ready(out_ready),
      .a_level(a_level), .b_level(b_level)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)",
                  nm, act, exp, $time);
      end
   endtask

   // behavioural model: two bounded queues and one output slot
   logic [WIDTH-1:0] mqa[$];
   logic [WIDTH-1:0] mqb[$];
   bit               m_ov = 1'b0;
   logic [WIDTH-1:0] m_data = '0;
   bit               m_src = 1'b0;
   bit               m_last = 1'b1;
   bit               m_pa, m_pb;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mqa.delete();
         mqb.delete();
         m_ov = 1'b0;
         m_data = '0;
         m_src = 1'b0;
         m_last = 1'b1;
      end else begin
         m_pa = a_valid && (mqa.size() < DEPTH);
         m_pb = b_valid && (mqb.size() < DEPTH);
         if (!m_ov || out_ready) begin
            if (mqa.size() > 0 && (mqb.size() == 0 || m_last)) begin
               m_data = mqa.pop_front();
               m_src = 1'b0;
               m_last = 1'b0;
               m_ov = 1'b1;
            end else if (mqb.size() > 0) begin
               m_data = mqb.pop_front();
               m_src = 1'b1;
               m_last = 1'b1;
               m_ov = 1'b1;
            end else begin
               m_ov = 1'b0;
            end
         end
         if (m_pa) mqa.push_back(a_data);
         if (m_pb) mqb.push_back(b_data);
      end
   end

   // compare process, away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         chk("out_valid", 32'(out_valid), 32'(m_ov));
         if (m_ov) begin
            chk("out_data", 32'(out_data), 32'(m_data));
            chk("out_src", 32'(out_src), 32'(m_src));
         end
         chk("a_level", 32'(a_level), 32'(mqa.size()));
         chk("b_level", 32'(b_level), 32'(mqb.size()));
         chk("a_ready", 32'(a_ready), 32'(mqa.size() != DEPTH));
         chk("b_ready", 32'(b_ready), 32'(mqb.size() != DEPTH));
      end
   end

   // transfer observer: accepted inputs and consumed outputs
   bit         a_acc = 1'b0;
   bit         b_acc = 1'b0;
   logic [8:0] olog[$];

   always @(posedge clk) begin
      a_acc = rst_n && a_valid && a_ready;
      b_acc = rst_n && b_valid && b_ready;
      if (rst_n && out_valid && out_ready)
         olog.push_back({out_src, out_data});
   end

   logic [7:0] fa[$];
   logic [7:0] fb[$];

   // producers holding valid/data until each word is accepted
   task automatic feed(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         if (a_acc && fa.size() > 0) fa.delete(0);
         if (b_acc && fb.size() > 0) fb.delete(0);
         a_valid = (fa.size() > 0);
         b_valid = (fb.size() > 0);
         if (a_valid) a_data = fa[0];
         if (b_valid) b_data = fb[0];
      end
   endtask

   task automatic do_reset();
      a_valid = 1'b0;
      b_valid = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic chk_log(input string nm, input logic [8:0] exp[$]);
      chk({nm, "_count"}, 32'(olog.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < olog.size(); i++)
         chk(nm, 32'(olog[i]), 32'(exp[i]));
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_ov"}, 32'(out_valid), 32'd0);
      chk({nm, "_od"}, 32'(out_data), 32'd0);
      chk({nm, "_os"}, 32'(out_src), 32'd0);
      chk({nm, "_al"}, 32'(a_level), 32'd0);
      chk({nm, "_bl"}, 32'(b_level), 32'd0);
      chk({nm, "_ar"}, 32'(a_ready), 32'd1);
      chk({nm, "_br"}, 32'(b_ready), 32'd1);
   endtask

   logic [8:0] exp_q[$];

   initial begin
      // reset values, asserted mid-cycle
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("rst");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk_en = 1'b1;

      // single word latency
      out_ready = 1'b1;
      a_valid = 1'b1;
      a_data = 8'h5A;
      @(negedge clk);
      a_valid = 1'b0;
      @(negedge clk);
      chk("lat_ov", 32'(out_valid), 32'd1);
      chk("lat_od", 32'(out_data), 32'h5A);
      chk("lat_os", 32'(out_src), 32'd0);
      @(negedge clk);
      chk("lat_ov_end", 32'(out_valid), 32'd0);

      // fairness: each input offers a word every other cycle
      do_reset();
      olog.delete();
      for (int i = 0; i < 8; i++) begin
         a_valid = 1'b1;
         b_valid = 1'b1;
         a_data = 8'(8'h10 + i);
         b_data = 8'(8'h20 + i);
         @(negedge clk);
         chk("fair_ar", 32'(a_ready), 32'd1);
         chk("fair_br", 32'(b_ready), 32'd1);
         a_valid = 1'b0;
         b_valid = 1'b0;
         @(negedge clk);
         chk("fair_ar", 32'(a_ready), 32'd1);
         chk("fair_br", 32'(b_ready), 32'd1);
      end
      repeat (4) @(negedge clk);
      exp_q.delete();
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back({1'b0, 8'(8'h10 + i)});
         exp_q.push_back({1'b1, 8'(8'h20 + i)});
      end
      chk_log("fair_seq", exp_q);

      // backpressure and full FIFOs
      do_reset();
      out_ready = 1'b0;
      fa = '{8'd1, 8'd2, 8'd3};
      fb = '{8'd7, 8'd8, 8'd9};
      feed(6);
      chk("bp_ov", 32'(out_valid), 32'd1);
      chk("bp_od", 32'(out_data), 32'd1);
      chk("bp_os", 32'(out_src), 32'd0);
      chk("bp_al", 32'(a_level), 32'd2);
      chk("bp_ar", 32'(a_ready), 32'd0);
      chk("bp_bl", 32'(b_level), 32'd2);
      chk("bp_br", 32'(b_ready), 32'd0);
      chk("bp_b9_pending", 32'(fb.size()), 32'd1);

      // output held stable while stalled
      for (int i = 0; i < 5; i++) begin
         feed(1);
         chk("hold_od", 32'(out_data), 32'd1);
         chk("hold_os", 32'(out_src), 32'd0);
         chk("hold_al", 32'(a_level), 32'd2);
         chk("hold_bl", 32'(b_level), 32'd2);
      end

      olog.delete();
      out_ready = 1'b1;
      feed(10);
      exp_q = '{9'h001, 9'h107, 9'h002, 9'h108, 9'h003, 9'h109};
      chk_log("bp_seq", exp_q);

      // reset while both FIFOs are full
      out_ready = 1'b0;
      fa = '{8'h31, 8'h32, 8'h33};
      fb = '{8'h41, 8'h42};
      feed(6);
      chk("pre_rst_al", 32'(a_level), 32'd2);
      chk("pre_rst_bl", 32'(b_level), 32'd2);
      a_valid = 1'b0;
      b_valid = 1'b0;
      olog.delete();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("mid_rst");
      #4 rst_n = 1'b1;
      @(negedge clk);
      chk_reset_vals("post_rst");
      out_ready = 1'b1;
      fa = '{8'h51};
      fb = '{8'h61};
      feed(6);
      exp_q = '{9'h051, 9'h161};
      chk_log("rst_seq", exp_q);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1, "watchdog");
   end

endmodule
